// File: rtl/vlsu_rbuf.sv
// vlsu_rbuf: credit-controlled read-return buffer for the vector load/store unit.
//
// An AR burst is forwarded to memory only when enough FIFO entries are reserved
// for every beat it returns. Memory therefore never sees R backpressure caused
// by load-unit stalls. Bursts longer than the FIFO take all credits and record
// the excess as debt. The first pops repay that debt before any credit returns.
//
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   slv_ar_i/valid_i/ready_o            AR from the address generator
//   mst_ar_o/valid_o/ready_i            AR to memory (payload passes through)
//   mst_r_i/valid_i/ready_o             R beats from memory
//   slv_r_o/valid_o/ready_i             R beats to the load unit (FIFO head)
//   credits_o                           free, unreserved FIFO entries
//   overflow_o                          sticky: a beat arrived while the FIFO was full

package vlsu_rbuf_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic        last;
    } r_t;

endpackage

module vlsu_rbuf #(
    parameter int unsigned Depth = 8,
    parameter type axi_ar_t = vlsu_rbuf_pkg::ar_t,
    parameter type axi_r_t  = vlsu_rbuf_pkg::r_t,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  axi_ar_t         slv_ar_i,
    input  logic            slv_ar_valid_i,
    output logic            slv_ar_ready_o,

    output axi_ar_t         mst_ar_o,
    output logic            mst_ar_valid_o,
    input  logic            mst_ar_ready_i,

    input  axi_r_t          mst_r_i,
    input  logic            mst_r_valid_i,
    output logic            mst_r_ready_o,

    output axi_r_t          slv_r_o,
    output logic            slv_r_valid_o,
    input  logic            slv_r_ready_i,

    output logic [CntW-1:0] credits_o,
    output logic            overflow_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned DebtW = 9;

    logic [CntW-1:0]  credits_q, credits_d;
    logic [DebtW-1:0] debt_q, debt_d;
    logic [DebtW-1:0] beats;
    logic             oversize;
    logic             allow;
    logic             ar_hs;

    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic             full, empty;
    logic             push, pop;
    logic             overflow_q;

    axi_r_t           mem [Depth];

    // ------------------------------------------------------------------
    // AR admission: combinational, gated by reserved FIFO space
    // ------------------------------------------------------------------
    assign beats    = DebtW'(slv_ar_i.len) + DebtW'(1);
    assign oversize = 32'(beats) > Depth;

    // Oversize bursts need the whole FIFO free and no debt left over.
    always_comb begin
        allow = 1'b0;
        if (debt_q == '0) begin
            if (oversize) begin
                allow = (32'(credits_q) == Depth);
            end else begin
                allow = (32'(credits_q) >= 32'(beats));
            end
        end
    end

    assign mst_ar_o       = slv_ar_i;
    assign mst_ar_valid_o = slv_ar_valid_i & allow;
    assign slv_ar_ready_o = mst_ar_ready_i & allow;
    assign ar_hs          = slv_ar_valid_i & mst_ar_ready_i & allow;

    // ------------------------------------------------------------------
    // Credit / debt bookkeeping
    // ------------------------------------------------------------------
    // A handshake needs debt == 0, so an AR and a debt-repaying pop never
    // coincide; a pop in the same cycle as an AR always returns a credit.
    always_comb begin
        credits_d = credits_q;
        debt_d    = debt_q;

        if (ar_hs) begin
            if (oversize) begin
                credits_d = '0;
                debt_d    = beats - DebtW'(Depth);
            end else begin
                credits_d = credits_q - CntW'(beats);
            end
        end

        if (pop) begin
            if (debt_q != '0) begin
                debt_d = debt_q - DebtW'(1);
            end else begin
                credits_d = credits_d + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= CntW'(Depth);
            debt_q    <= '0;
        end else begin
            credits_q <= credits_d;
            debt_q    <= debt_d;
        end
    end

    assign credits_o = credits_q;

    // ------------------------------------------------------------------
    // R FIFO: circular buffer, one extra pointer bit distinguishes full/empty
    // ------------------------------------------------------------------
    assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign mst_r_ready_o = !full;
    assign slv_r_valid_o = !empty;
    assign slv_r_o       = mem[rd_ptr_q[AddrW-1:0]];

    assign push = mst_r_valid_i & !full;
    assign pop  = !empty & slv_r_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage carries no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q[AddrW-1:0]] <= mst_r_i;
        end
    end

    // Sticky protocol-violation flag; the offending beat is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (mst_r_valid_i && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_vlsu_rbuf.sv
// tb_vlsu_rbuf: directed bench for vlsu_rbuf (Depth = 8) with an R-beat scoreboard.
module tb_vlsu_rbuf;
    import vlsu_rbuf_pkg::*;

    localparam int unsigned Depth = 8;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic            clk;
    logic            rst_ni;
    ar_t             slv_ar;
    logic            slv_ar_valid;
    logic            slv_ar_ready;
    ar_t             mst_ar;
    logic            mst_ar_valid;
    logic            mst_ar_ready;
    r_t              mst_r;
    logic            mst_r_valid;
    logic            mst_r_ready;
    r_t              slv_r;
    logic            slv_r_valid;
    logic            slv_r_ready;
    logic [CntW-1:0] credits;
    logic            overflow;

    int     n_pass  = 0;
    int     n_fail  = 0;
    int     n_total = 0;
    int     seq     = 0;
    r_t     sb[$];
    logic   pu, po;

    vlsu_rbuf #(
        .Depth    (Depth),
        .axi_ar_t (ar_t),
        .axi_r_t  (r_t)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .slv_ar_i       (slv_ar),
        .slv_ar_valid_i (slv_ar_valid),
        .slv_ar_ready_o (slv_ar_ready),
        .mst_ar_o       (mst_ar),
        .mst_ar_valid_o (mst_ar_valid),
        .mst_ar_ready_i (mst_ar_ready),
        .mst_r_i        (mst_r),
        .mst_r_valid_i  (mst_r_valid),
        .mst_r_ready_o  (mst_r_ready),
        .slv_r_o        (slv_r),
        .slv_r_valid_o  (slv_r_valid),
        .slv_r_ready_i  (slv_r_ready),
        .credits_o      (credits),
        .overflow_o     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of R traffic; called at posedge+1, returns at the next posedge+1.
    task automatic cyc(input logic rv, input logic rr, output logic pushed, output logic popped);
        r_t exp;
        mst_r_valid = rv;
        mst_r.id    = 4'h3;
        mst_r.data  = 64'(seq) + 64'hBEEF_0000;
        mst_r.last  = 1'b0;
        slv_r_ready = rr;
        #1;
        pushed = rv && mst_r_ready;
        popped = slv_r_valid && rr;
        if (popped) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", 64'(slv_r.data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp = sb.pop_front();
                chk("r_data", 64'(slv_r.data), 64'(exp.data));
            end
        end
        if (pushed) begin
            sb.push_back(mst_r);
            seq++;
        end
        @(posedge clk);
        #1;
        mst_r_valid = 1'b0;
        slv_r_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 32 && sb.size() != 0; i++) begin
            cyc(1'b0, 1'b1, pu, po);
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(slv_r_valid), 64'd0);
    endtask

    // Present one AR and complete its handshake.
    task automatic issue_ar(input logic [7:0] len);
        slv_ar.len   = len;
        slv_ar_valid = 1'b1;
        #1;
        chk("ar_issue_valid", 64'(mst_ar_valid), 64'd1);
        @(posedge clk);
        #1;
        slv_ar_valid = 1'b0;
    endtask

    initial begin
        int pushes;
        int pops;
        logic [7:0] dummy;

        rst_ni       = 1'b0;
        slv_ar       = '0;
        slv_ar.id    = 4'h1;
        slv_ar.addr  = 32'h0000_1000;
        slv_ar_valid = 1'b0;
        mst_ar_ready = 1'b1;
        mst_r        = '0;
        mst_r_valid  = 1'b0;
        slv_r_ready  = 1'b0;
        dummy        = 8'd0;

        // Reset values
        #12;
        chk("rst_credits", 64'(credits), 64'd8);
        chk("rst_r_valid", 64'(slv_r_valid), 64'd0);
        chk("rst_r_ready", 64'(mst_r_ready), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_ar_valid", 64'(mst_ar_valid), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Credit throttle: 4 beats, then 5 beats held until one pop
        slv_ar.len   = 8'd3;
        slv_ar_valid = 1'b1;
        #1;
        chk("thr_ar1_valid", 64'(mst_ar_valid), 64'd1);
        chk("thr_ar1_ready", 64'(slv_ar_ready), 64'd1);
        chk("thr_ar_payload", 64'(mst_ar), 64'(slv_ar));
        @(posedge clk);
        #1;
        slv_ar.len = 8'd4;
        #1;
        chk("thr_credits4", 64'(credits), 64'd4);
        chk("thr_ar2_held", 64'(mst_ar_valid), 64'd0);
        chk("thr_ar2_ready_low", 64'(slv_ar_ready), 64'd0);
        repeat (4) cyc(1'b1, 1'b0, pu, po);
        chk("thr_still_held", 64'(mst_ar_valid), 64'd0);
        cyc(1'b0, 1'b1, pu, po);
        chk("thr_credits5", 64'(credits), 64'd5);
        chk("thr_ar2_released", 64'(mst_ar_valid), 64'd1);
        @(posedge clk);
        #1;
        slv_ar_valid = 1'b0;
        chk("thr_credits0", 64'(credits), 64'd0);
        repeat (5) cyc(1'b1, 1'b1, pu, po);
        drain();
        chk("thr_credits_back", 64'(credits), 64'd8);

        // Latency / throughput: 8 back-to-back beats, ready high
        issue_ar(8'd7);
        for (int i = 0; i < 8; i++) begin
            #0;
            chk("tp_r_valid", 64'(slv_r_valid), (i == 0) ? 64'd0 : 64'd1);
            chk("tp_mst_ready", 64'(mst_r_ready), 64'd1);
            cyc(1'b1, 1'b1, pu, po);
        end
        chk("tp_last_valid", 64'(slv_r_valid), 64'd1);
        cyc(1'b0, 1'b1, pu, po);
        chk("tp_empty", 64'(slv_r_valid), 64'd0);
        chk("tp_credits", 64'(credits), 64'd8);

        // Full / backpressure / overflow
        issue_ar(8'd7);
        repeat (8) cyc(1'b1, 1'b0, pu, po);
        chk("full_ready_low", 64'(mst_r_ready), 64'd0);
        chk("full_overflow0", 64'(overflow), 64'd0);
        cyc(1'b1, 1'b0, pu, po);
        chk("ovf_not_pushed", 64'(pu), 64'd0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_ready_low", 64'(mst_r_ready), 64'd0);
        cyc(1'b0, 1'b1, pu, po);
        chk("full_pop_ready", 64'(mst_r_ready), 64'd1);
        drain();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("full_credits", 64'(credits), 64'd8);

        // Oversize burst: waits for a fully free FIFO, then pays debt first
        issue_ar(8'd1);
        slv_ar.len   = 8'd15;
        slv_ar_valid = 1'b1;
        #1;
        chk("ovs_held", 64'(mst_ar_valid), 64'd0);
        chk("ovs_credits6", 64'(credits), 64'd6);
        repeat (2) cyc(1'b1, 1'b0, pu, po);
        chk("ovs_held2", 64'(mst_ar_valid), 64'd0);
        repeat (2) cyc(1'b0, 1'b1, pu, po);
        chk("ovs_credits8", 64'(credits), 64'd8);
        chk("ovs_released", 64'(mst_ar_valid), 64'd1);
        @(posedge clk);
        #1;
        slv_ar_valid = 1'b0;
        chk("ovs_credits0", 64'(credits), 64'd0);
        pushes = 0;
        pops   = 0;
        for (int i = 0; i < 200 && pops < 16; i++) begin
            cyc(pushes < 16, (i % 4) == 3, pu, po);
            if (pu) pushes++;
            if (po) pops++;
            chk("ovs_credits", 64'(credits), (pops <= 8) ? 64'd0 : 64'(pops - 8));
        end
        chk("ovs_pops", 64'(pops), 64'd16);
        chk("ovs_pushes", 64'(pushes), 64'd16);
        chk("ovs_credits_back", 64'(credits), 64'd8);
        chk("ovs_no_new_ovf_empty", 64'(slv_r_valid), 64'd0);

        // Reset mid-burst, asynchronous
        issue_ar(8'd3);
        repeat (2) cyc(1'b1, 1'b0, pu, po);
        chk("mid_credits", 64'(credits), 64'd4);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_credits", 64'(credits), 64'd8);
        chk("mid_rst_r_valid", 64'(slv_r_valid), 64'd0);
        chk("mid_rst_r_ready", 64'(mst_r_ready), 64'd1);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        issue_ar(8'd0);
        chk("post_rst_credits", 64'(credits), 64'd7);
        cyc(1'b1, 1'b0, pu, po);
        drain();
        chk("post_rst_credits_back", 64'(credits), 64'd8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
